// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line levels and parity helpers
// Used by the fifo-fed transmitter and, later, the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL    = 1'b1;
  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Widest supported frame payload; the bit counter must also reach STOP_BITS-1.
  localparam int MAX_DATA_W = 9;
  localparam int BIT_CNT_W  = 4;

  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// rtl/uart_fifo_tx_if.sv - show-ahead fifo read port between the TX fifo and its reader
// The fifo drives the master side; the transmitter is the only slave.
interface uart_fifo_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_do;
  logic                  fifo_re;

  modport master (
    output fifo_empty,
    output fifo_do,
    input  fifo_re
  );

  modport slave (
    input  fifo_empty,
    input  fifo_do,
    output fifo_re
  );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - restartable bit-period counter with latched divisor
// o_tick marks the last clk of each bit; i_load restarts the period and samples i_div.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div_q;

  assign o_tick = (r_cnt == r_div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_div_q <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_div_q <= i_div;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - UART transmitter popping one fifo word per serial frame
// Frame: start, DATA_WIDTH bits LSB-first, optional parity, STOP_BITS stop bits.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  uart_fifo_tx_if.slave        fifo,
  output logic                 tx,
  output logic                 busy
);

  localparam logic ODD_BIT = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_parity;
  logic                  r_tx;
  logic                  w_fifo_re;
  logic                  w_tick;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // Gated by reset so a word is never popped while the FSM is being forced to IDLE.
  assign w_fifo_re    = (r_state == ST_IDLE) && en && !fifo.fifo_empty && !reset;
  assign fifo.fifo_re = w_fifo_re;
  assign busy         = (r_state != ST_IDLE) || w_fifo_re;
  assign tx           = r_tx;
  assign w_shift_nxt  = r_shift >> 1;

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_fifo_re),
    .i_div  (div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tx      <= TX_IDLE_LEVEL;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx      <= TX_IDLE_LEVEL;
          r_bit_cnt <= '0;
          if (w_fifo_re) begin
            r_shift  <= fifo.fifo_do;
            r_parity <= parity_bit(MAX_DATA_W'(fifo.fifo_do), ODD_BIT);
            r_tx     <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_nxt;
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= TX_IDLE_LEVEL;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= w_shift_nxt[0];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= TX_IDLE_LEVEL;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= TX_IDLE_LEVEL;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - scoreboard bench for uart_fifo_tx across parity and stop-bit variants
// Each instance has its own fifo model and expected-word queue; a monitor decodes tx frames.
module tb_uart_fifo_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div = 16'd3;

  always #5 clk = ~clk;

  uart_fifo_tx_if f0 ();
  uart_fifo_tx_if f1 ();
  uart_fifo_tx_if f2 ();
  uart_fifo_tx_if f3 ();

  wire [3:0] txv;
  wire [3:0] busyv;
  wire [3:0] re;

  uart_fifo_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .div(div), .fifo(f0), .tx(txv[0]), .busy(busyv[0]));
  uart_fifo_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .div(div), .fifo(f1), .tx(txv[1]), .busy(busyv[1]));
  uart_fifo_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .div(div), .fifo(f2), .tx(txv[2]), .busy(busyv[2]));
  uart_fifo_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .en(en), .div(div), .fifo(f3), .tx(txv[3]), .busy(busyv[3]));

  // Fifo models: bench writes mem/wr, the pop process advances rd on fifo_re.
  logic [7:0] mem [4][16];
  int         wr [4];
  int         rd [4];

  assign f0.fifo_empty = (wr[0] == rd[0]);
  assign f1.fifo_empty = (wr[1] == rd[1]);
  assign f2.fifo_empty = (wr[2] == rd[2]);
  assign f3.fifo_empty = (wr[3] == rd[3]);
  assign f0.fifo_do    = mem[0][rd[0][3:0]];
  assign f1.fifo_do    = mem[1][rd[1][3:0]];
  assign f2.fifo_do    = mem[2][rd[2][3:0]];
  assign f3.fifo_do    = mem[3][rd[3][3:0]];
  assign re = {f3.fifo_re, f2.fifo_re, f1.fifo_re, f0.fifo_re};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (re[k]) rd[k] <= rd[k] + 1;
    end
  end

  int nb [4] = '{10, 11, 11, 11};
  int pe [4] = '{0, 1, 1, 0};
  int po [4] = '{0, 0, 1, 0};

  logic [7:0] q0[$], q1[$], q2[$], q3[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void sb_push(input int k, input logic [7:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endfunction

  function automatic logic [8:0] sb_pop(input int k);
    logic [8:0] r = '0;
    case (k)
      0: if (q0.size() > 0) r = {1'b1, q0.pop_front()};
      1: if (q1.size() > 0) r = {1'b1, q1.pop_front()};
      2: if (q2.size() > 0) r = {1'b1, q2.pop_front()};
      default: if (q3.size() > 0) r = {1'b1, q3.pop_front()};
    endcase
    return r;
  endfunction

  function automatic int sb_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [15:0] frame_bits(input int k, input logic [7:0] w);
    logic [15:0] f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 8; j++) f[1 + j] = w[j];
    if (pe[k] != 0) f[9] = (^w) ^ po[k][0];
    return f;
  endfunction

  task automatic push(input int k, input logic [7:0] w);
    mem[k][wr[k][3:0]] = w;
    wr[k]++;
    sb_push(k, w);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Samples first and last clk of every bit so widths are checked as well as values.
  task automatic mon(input int k);
    forever begin
      @(negedge clk);
      if (txv[k] === 1'b0 && !reset) begin
        int          p;
        logic [15:0] gf;
        logic [15:0] gl;
        bit          ab;
        logic [8:0]  e;
        p  = int'(div) + 1;
        gf = '1;
        gl = '1;
        ab = 1'b0;
        for (int c = 0; c < nb[k] * p; c++) begin
          if (c > 0) @(negedge clk);
          if (reset) begin
            ab = 1'b1;
            break;
          end
          if (c % p == 0) gf[c / p] = txv[k];
          if (c % p == p - 1) gl[c / p] = txv[k];
        end
        e = sb_pop(k);
        if (!ab) begin
          check($sformatf("frame_expected_dut%0d", k), 32'(e[8]), 32'd1);
          check($sformatf("frame_first_dut%0d", k), 32'(gf), 32'(frame_bits(k, e[7:0])));
          check($sformatf("frame_last_dut%0d", k), 32'(gl), 32'(frame_bits(k, e[7:0])));
        end
      end
    end
  endtask

  task automatic wait_idle(input int k);
    bit done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sb_size(k) == 0 && !busyv[k]) begin
        done = 1'b1;
        break;
      end
    end
    check($sformatf("drain_dut%0d", k), 32'(done), 32'd1);
  endtask

  task automatic pulse_gaps(input int k, input int npulse, input int gap, input int budget);
    int t[$];
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (re[k]) t.push_back(c);
    end
    check($sformatf("pop_count_dut%0d", k), 32'(t.size()), 32'(npulse));
    for (int i = 1; i < t.size(); i++)
      check($sformatf("pop_gap_dut%0d", k), 32'(t[i] - t[i - 1]), 32'(gap));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int bc;
    bit seen_re;
    bit seen_low;

    step(3);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_tx_dut%0d", k), 32'(txv[k]), 32'd1);
      check($sformatf("reset_busy_dut%0d", k), 32'(busyv[k]), 32'd0);
      check($sformatf("reset_re_dut%0d", k), 32'(re[k]), 32'd0);
    end
    step(1);
    reset = 1'b0;
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none

    // Non-empty fifo with en low: nothing moves.
    div = 16'd3;
    push(0, 8'hA5);
    seen_re  = 1'b0;
    seen_low = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_re  = seen_re | re[0];
      seen_low = seen_low | !txv[0];
    end
    check("en0_no_pop", 32'(seen_re), 32'd0);
    check("en0_tx_idle", 32'(seen_low), 32'd0);

    // Single 0xA5 frame, 4 clk per bit.
    step(1);
    en = 1'b1;
    r  = rd[0];
    bc = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) check("pop_next_cycle", 32'(re[0]), 32'd1);
      bc += int'(busyv[0]);
    end
    check("busy_cycles", 32'(bc), 32'd41);
    wait_idle(0);
    check("single_pop", 32'(rd[0] - r), 32'd1);

    // Three words back to back at div = 0.
    step(1);
    div = 16'd0;
    push(0, 8'h3C);
    push(0, 8'hFF);
    push(0, 8'h00);
    pulse_gaps(0, 3, 11, 60);
    wait_idle(0);

    // Parity variants.
    step(1);
    push(1, 8'h07);
    push(2, 8'h07);
    push(1, 8'hC3);
    push(2, 8'h6B);
    wait_idle(1);
    wait_idle(2);

    // Two stop bits at div = 1.
    step(1);
    div = 16'd1;
    push(3, 8'h96);
    push(3, 8'h69);
    pulse_gaps(3, 2, 23, 80);
    wait_idle(3);

    // en dropped during data bit 3: frame completes, second word stays queued.
    step(1);
    en = 1'b0;
    push(0, 8'h5A);
    push(0, 8'h81);
    step(2);
    r  = rd[0];
    en = 1'b1;
    step(9);
    en = 1'b0;
    step(40);
    check("en_drop_pops", 32'(rd[0] - r), 32'd1);
    check("en_drop_tx_idle", 32'(txv[0]), 32'd1);
    check("en_drop_busy", 32'(busyv[0]), 32'd0);

    // Reset during data bit 5 of 0x81: word lost, 0x42 follows intact.
    push(0, 8'h42);
    r  = rd[0];
    en = 1'b1;
    step(13);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    check("midframe_reset_tx", 32'(txv[0]), 32'd1);
    check("midframe_reset_busy", 32'(busyv[0]), 32'd0);
    step(1);
    reset = 1'b0;
    wait_idle(0);
    check("reset_pops", 32'(rd[0] - r), 32'd2);

    step(2);
    for (int k = 0; k < 4; k++)
      check($sformatf("sb_empty_dut%0d", k), 32'(sb_size(k)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
